// File: rtl/bytes_to_word_pkg.sv
// Shared constants and helpers for the byte-to-word packer.
package bytes_to_word_pkg;

    localparam int BYTE_W = 8;

    // Returns the byte-counter value whose accept writes the given output lane.
    // Little-endian writes lane k on count k. Big-endian fills from the top lane down.
    function automatic int lane_slot(input int lane, input int word_bytes, input bit big_endian);
        return big_endian ? (word_bytes - 1 - lane) : lane;
    endfunction

endpackage

// File: rtl/bytes_to_word.sv
// Byte-stream to word-stream packer. Collects WORD_BYTES accepted bytes
// into a staging register and emits them as one registered word on a
// valid/ready output. Non-final bytes never stall. Only the completing
// byte waits for the previous word to drain.
module bytes_to_word
    import bytes_to_word_pkg::*;
#(
    parameter int WORD_BYTES = 4,
    parameter bit BIG_ENDIAN = 1'b0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    byte_valid,
    output logic                    byte_ready,
    input  logic [7:0]              byte_data,
    output logic                    word_valid,
    input  logic                    word_ready,
    output logic [8*WORD_BYTES-1:0] word_data
);

    localparam int WORD_BITS = BYTE_W * WORD_BYTES;
    localparam int CNT_W     = $clog2(WORD_BYTES);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WORD_BYTES - 1);

    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [WORD_BITS-1:0] stage_q, stage_d;
    logic [WORD_BITS-1:0] word_data_q, word_data_d;
    logic                 word_valid_q, word_valid_d;

    logic byte_fire;
    logic word_fire;
    logic completing;

    // Handshake decode. The final byte of a word may only enter when the
    // output slot is empty or is being emptied on this same edge.
    always_comb begin
        byte_ready = (cnt_q != LAST) || !word_valid_q || word_ready;
        byte_fire  = byte_valid && byte_ready;
        word_fire  = word_valid_q && word_ready;
        completing = byte_fire && (cnt_q == LAST);
    end

    // Each lane takes the incoming byte when the counter points at it.
    // Other lanes keep whatever they hold. Stale data is harmless because
    // every lane is rewritten before the word is emitted.
    for (genvar gi = 0; gi < WORD_BYTES; gi++) begin : g_lane
        localparam logic [CNT_W-1:0] SLOT = CNT_W'(lane_slot(gi, WORD_BYTES, BIG_ENDIAN));
        assign stage_d[gi*BYTE_W +: BYTE_W] =
            (byte_fire && (cnt_q == SLOT)) ? byte_data : stage_q[gi*BYTE_W +: BYTE_W];
    end

    // Counter advance, word capture and output-valid bookkeeping.
    always_comb begin
        cnt_d        = cnt_q;
        word_data_d  = word_data_q;
        word_valid_d = word_valid_q;

        if (byte_fire) begin
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CNT_W'(1);
        end

        if (completing) begin
            // The new word replaces a draining one on the same edge: no bubble.
            word_data_d  = stage_d;
            word_valid_d = 1'b1;
        end else if (word_fire) begin
            word_valid_d = 1'b0;
        end
    end

    // State registers. Reset discards any partially assembled word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q        <= '0;
            stage_q      <= '0;
            word_data_q  <= '0;
            word_valid_q <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            stage_q      <= stage_d;
            word_data_q  <= word_data_d;
            word_valid_q <= word_valid_d;
        end
    end

    assign word_valid = word_valid_q;
    assign word_data  = word_data_q;

endmodule

// File: tb/tb_bytes_to_word.sv
// Self-checking bench for bytes_to_word (WORD_BYTES=4). A little-endian and
// a big-endian instance share one input stream. A queue-based model tracks
// accepted bytes and pending words and checks every edge.
module tb_bytes_to_word;

    logic        clk = 1'b0;
    logic        rst;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        word_ready;
    logic        byte_ready, byte_ready_be;
    logic        word_valid, word_valid_be;
    logic [31:0] word_data, word_data_be;

    int checks = 0;
    int errors = 0;
    int words_seen = 0;

    always #5 clk = ~clk;

    bytes_to_word #(.WORD_BYTES(4), .BIG_ENDIAN(1'b0)) dut_le (
        .clk(clk), .rst(rst),
        .byte_valid(byte_valid), .byte_ready(byte_ready), .byte_data(byte_data),
        .word_valid(word_valid), .word_ready(word_ready), .word_data(word_data)
    );

    bytes_to_word #(.WORD_BYTES(4), .BIG_ENDIAN(1'b1)) dut_be (
        .clk(clk), .rst(rst),
        .byte_valid(byte_valid), .byte_ready(byte_ready_be), .byte_data(byte_data),
        .word_valid(word_valid_be), .word_ready(word_ready), .word_data(word_data_be)
    );

    task automatic check(input bit ok, input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] bswap(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // ---------------- reference model ----------------
    // pend: bytes accepted toward the next word; wq: words the block owes downstream.
    logic [7:0]  pend[$];
    logic [31:0] wq[$];

    always @(posedge clk) begin
        bit          exp_rdy;
        logic [31:0] w;
        if (rst) begin
            pend.delete();
            wq.delete();
        end else begin
            exp_rdy = !(pend.size() == 3 && wq.size() != 0 && !word_ready);
            check(byte_ready == exp_rdy, "byte_ready", 64'(byte_ready), 64'(exp_rdy));
            check(byte_ready_be == exp_rdy, "byte_ready_be", 64'(byte_ready_be), 64'(exp_rdy));
            check(word_valid == (wq.size() != 0), "word_valid", 64'(word_valid), 64'(wq.size() != 0));
            check(word_valid_be == (wq.size() != 0), "word_valid_be", 64'(word_valid_be), 64'(wq.size() != 0));
            if (word_ready && wq.size() != 0) begin
                w = wq.pop_front();
                check(word_data == w, "word_data_le", 64'(word_data), 64'(w));
                check(word_data_be == bswap(w), "word_data_be", 64'(word_data_be), 64'(bswap(w)));
                $display("word %0d: le=%08h be=%08h", words_seen, word_data, word_data_be);
                words_seen++;
            end
            if (byte_valid && exp_rdy) begin
                pend.push_back(byte_data);
                if (pend.size() == 4) begin
                    wq.push_back({pend[3], pend[2], pend[1], pend[0]});
                    pend.delete();
                end
            end
        end
    end

    // ---------------- directed vectors ----------------
    typedef struct {
        logic        bv;
        logic [7:0]  bd;
        logic        wr;
        logic        exp_rdy;  // byte_ready before the edge
        logic        exp_wv;   // word_valid after the edge
        logic [31:0] exp_wd;   // LE word_data after the edge (when exp_wv)
    } vec_t;

    vec_t tbl[16];

    initial begin
        int base;
        rst = 1'b1; byte_valid = 1'b0; byte_data = 8'h00; word_ready = 1'b0;

        // Basic little-endian word, valid for exactly one cycle.
        tbl[0]  = '{1'b1, 8'h11, 1'b1, 1'b1, 1'b0, 32'h0};
        tbl[1]  = '{1'b1, 8'h22, 1'b1, 1'b1, 1'b0, 32'h0};
        tbl[2]  = '{1'b1, 8'h33, 1'b1, 1'b1, 1'b0, 32'h0};
        tbl[3]  = '{1'b1, 8'h44, 1'b1, 1'b1, 1'b1, 32'h44332211};
        tbl[4]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 32'h0};
        // Backpressure: hold first word, accept three more, stall the fourth.
        tbl[5]  = '{1'b1, 8'h00, 1'b0, 1'b1, 1'b0, 32'h0};
        tbl[6]  = '{1'b1, 8'h01, 1'b0, 1'b1, 1'b0, 32'h0};
        tbl[7]  = '{1'b1, 8'h02, 1'b0, 1'b1, 1'b0, 32'h0};
        tbl[8]  = '{1'b1, 8'h03, 1'b0, 1'b1, 1'b1, 32'h03020100};
        tbl[9]  = '{1'b1, 8'h04, 1'b0, 1'b1, 1'b1, 32'h03020100};
        tbl[10] = '{1'b1, 8'h05, 1'b0, 1'b1, 1'b1, 32'h03020100};
        tbl[11] = '{1'b1, 8'h06, 1'b0, 1'b1, 1'b1, 32'h03020100};
        tbl[12] = '{1'b1, 8'h07, 1'b0, 1'b0, 1'b1, 32'h03020100};
        tbl[13] = '{1'b1, 8'h07, 1'b0, 1'b0, 1'b1, 32'h03020100};
        tbl[14] = '{1'b1, 8'h07, 1'b1, 1'b1, 1'b1, 32'h07060504};
        tbl[15] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 32'h0};

        // Reset state.
        step();
        step();
        check(word_valid == 1'b0, "reset_word_valid", 64'(word_valid), 64'h0);
        check(word_data == 32'h0, "reset_word_data", 64'(word_data), 64'h0);
        check(byte_ready == 1'b1, "reset_byte_ready", 64'(byte_ready), 64'h1);
        rst = 1'b0;

        for (int i = 0; i < 16; i++) begin
            byte_valid = tbl[i].bv; byte_data = tbl[i].bd; word_ready = tbl[i].wr;
            #1;
            check(byte_ready == tbl[i].exp_rdy, $sformatf("vec%0d_ready", i), 64'(byte_ready), 64'(tbl[i].exp_rdy));
            step();
            check(word_valid == tbl[i].exp_wv, $sformatf("vec%0d_wvalid", i), 64'(word_valid), 64'(tbl[i].exp_wv));
            if (tbl[i].exp_wv) begin
                check(word_data == tbl[i].exp_wd, $sformatf("vec%0d_wdata", i), 64'(word_data), 64'(tbl[i].exp_wd));
                check(word_data_be == bswap(tbl[i].exp_wd), $sformatf("vec%0d_wdata_be", i),
                      64'(word_data_be), 64'(bswap(tbl[i].exp_wd)));
            end
            $display("vec %0d: bv=%0b bd=%02h wr=%0b -> rdy=%0b wv=%0b wd=%08h",
                     i, tbl[i].bv, tbl[i].bd, tbl[i].wr, byte_ready, word_valid, word_data);
        end

        // Reset mid-word: AA/BB must not leak into the next word.
        byte_valid = 1'b1; word_ready = 1'b1;
        byte_data = 8'hAA; step();
        byte_data = 8'hBB; step();
        byte_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        check(word_valid == 1'b0, "rst_mid_wvalid", 64'(word_valid), 64'h0);
        check(word_data == 32'h0, "rst_mid_wdata", 64'(word_data), 64'h0);
        step();
        check(word_valid == 1'b0, "rst_hold_wvalid", 64'(word_valid), 64'h0);
        rst = 1'b0;
        byte_valid = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            byte_data = 8'(i);
            step();
        end
        byte_valid = 1'b0;
        check(word_valid == 1'b1, "post_rst_wvalid", 64'(word_valid), 64'h1);
        check(word_data == 32'h04030201, "post_rst_wdata", 64'(word_data), 64'h04030201);
        check(word_data_be == 32'h01020304, "post_rst_wdata_be", 64'(word_data_be), 64'h01020304);
        step();
        check(word_valid == 1'b0, "post_rst_drain", 64'(word_valid), 64'h0);

        // Streaming: 1000 random bytes at full rate give 250 words.
        base = words_seen;
        byte_valid = 1'b1; word_ready = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            byte_data = 8'($urandom);
            #1;
            check(byte_ready == 1'b1, "stream_ready", 64'(byte_ready), 64'h1);
            step();
        end
        byte_valid = 1'b0;
        step();
        step();
        check(words_seen - base == 250, "stream_words", 64'(words_seen - base), 64'd250);

        // Random handshakes on both sides.
        for (int i = 0; i < 3000; i++) begin
            byte_valid = 1'($urandom);
            byte_data  = 8'($urandom);
            word_ready = ($urandom_range(0, 3) != 0);
            step();
        end
        byte_valid = 1'b0; word_ready = 1'b1;
        step();
        step();
        check(wq.size() == 0, "random_drain", 64'(wq.size()), 64'h0);
        check(word_valid == 1'b0, "random_final_wvalid", 64'(word_valid), 64'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/bytes_to_word.md
Name: bytes_to_word

Overview:
Byte-stream to word-stream packer, the inverse of word_to_bytes. Accepts bytes on a valid/ready stream and emits one word per WORD_BYTES accepted bytes on a valid/ready stream. Sits between byte-wide links (UART/SPI receivers, byte FIFOs) and word-wide consumers. Paired with word_to_bytes, it forms a lossless loopback.

Parameters:
WORD_BYTES, 4, bytes per output word; legal values 2..8.
BIG_ENDIAN, 0, 0: first accepted byte lands in word_data[7:0]; 1: first accepted byte lands in the most-significant byte.

Ports:
clk  input  1  clock; all state changes on the rising edge
rst  input  1  asynchronous, active-high reset
byte_valid  input  1  upstream byte present
byte_ready  output  1  block accepts the byte this cycle
byte_data  input  8  upstream byte
word_valid  output  1  assembled word present
word_ready  input  1  downstream accepts the word this cycle
word_data  output  8*WORD_BYTES  assembled word

Behaviour:
- Transfer rule on both sides: a transfer occurs on a rising edge where valid && ready are both high. Data is sampled only on transfer.
- State:
  - staging register stage[8*WORD_BYTES-1:0];
  - byte counter cnt, 0..WORD_BYTES-1, width $clog2(WORD_BYTES);
  - output register word_data plus word_valid flag.
- Reset (async, immediate) values:
  - cnt=0, word_valid=0, word_data=0, stage=0.
  - Any partially assembled word is discarded.
  - No transfer is counted on the edge where rst is high.
- byte_ready, combinational:
  - byte_ready = (cnt != WORD_BYTES-1) || !word_valid || word_ready.
  - Non-final bytes are always accepted, even while an output word is pending.
  - The final byte of a word stalls only if the previous word has not drained.
- byte_ready has no dependency on byte_valid. word_valid and word_data are registered, with no combinational input-to-output path.
- Byte accept with cnt < WORD_BYTES-1:
  - write byte_data into byte lane cnt (BIG_ENDIAN=0) or lane WORD_BYTES-1-cnt (BIG_ENDIAN=1);
  - cnt <= cnt+1.
- Byte accept with cnt == WORD_BYTES-1:
  - word_data <= stage with the final lane replaced by byte_data;
  - word_valid <= 1; cnt <= 0.
- Word transfer (word_valid && word_ready) with no simultaneous completing byte: word_valid <= 0.
- Simultaneous word transfer and completing byte: the new word replaces the old one and word_valid stays 1. This is a back-to-back word, with no bubble.
- Latency: word_valid rises on the cycle after the accept of the final byte.
- Throughput: 1 byte/cycle sustained when word_ready is held high.
- word_data is held stable while word_valid && !word_ready. The AXI-style rule applies: once asserted, word_valid never drops without a transfer.
- Stale upper-lane contents in stage need not be cleared; every lane is overwritten before use.
- Wrap-around: cnt wraps WORD_BYTES-1 -> 0 only on a completing accept.
- Reset mid-word: partial bytes are lost. The first byte after reset lands in lane 0 (or the MSB lane if BIG_ENDIAN).

Decomposition:
- No package required. Localparams inside the module: WORD_BITS = 8*WORD_BYTES, CNT_W = $clog2(WORD_BYTES).
- No sub-module; a single flat module of roughly 120-150 lines.
- Bench reuses the existing power_on_reset, random_source and random_sink blocks.
- Loopback bench: random_source(32) -> word_to_bytes -> bytes_to_word -> scoreboard.

Test Plan:
- Basic LE: WORD_BYTES=4, BIG_ENDIAN=0, bytes 0x11,0x22,0x33,0x44 on consecutive cycles, word_ready=1 -> single word 0x44332211, word_valid high exactly one cycle, one cycle after the 0x44 accept.
- BE: same bytes with BIG_ENDIAN=1 -> word 0x11223344.
- Backpressure: word_ready=0, feed 8 bytes 0x00..0x07 ->
  - word 0x03020100 is held stable;
  - bytes 0x04..0x06 are accepted;
  - byte_ready drops with 0x07 pending;
  - raising word_ready drains 0x03020100, accepts 0x07 in the same cycle, then presents 0x07060504 with no bubble.
- Streaming: 1000 random bytes with byte_valid and word_ready always 1 -> byte_ready never low, 250 words, scoreboard match.
- Reset mid-word: accept 0xAA,0xBB, assert rst, then send 0x01..0x04 -> word_valid=0 during and after reset, word 0x04030201 with no AA/BB contamination.
- Loopback soak: random_source(32, SPEED 3) -> word_to_bytes -> bytes_to_word -> random_sink(32, SPEED 1), 100000 time units -> every output word equals the corresponding input word, in order, with no drops.
